// File: rtl/exp_pkg.sv
// Shared definitions for the e^x Taylor-series controller: Q-format widths,
// the Q16 constant 1.0 and the controller state encoding.
package exp_pkg;

  localparam int X_W    = 16;  // Q0.16 operand
  localparam int TERM_W = 17;  // Q1.16 running term
  localparam int SUM_W  = 18;  // Q2.16 accumulated sum
  localparam int ADDR_W = 4;   // reciprocal ROM address

  localparam logic [TERM_W-1:0] ONE_Q16 = 17'h1_0000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MUL,
    ACC,
    DONE
  } state_e;

endpackage : exp_pkg

// File: rtl/fx_mul_trunc.sv
// Unsigned Q1.16 x Q0.16 multiply returning the Q1.16 product, truncated
// (bits [32:16] of the full 33-bit product). Purely combinational.
module fx_mul_trunc
  import exp_pkg::*;
(
  input  logic [TERM_W-1:0] a_i,
  input  logic [X_W-1:0]    b_i,
  output logic [TERM_W-1:0] p_o
);

  logic [X_W-1:0] frac_unused;

  assign {p_o, frac_unused} = {{X_W{1'b0}}, a_i} * {{TERM_W{1'b0}}, b_i};

endmodule : fx_mul_trunc

// File: rtl/exp_taylor_ctrl.sv
// Sequential e^x evaluator: sums N_TERMS Taylor terms after 1.0, forming each
// term as term * x * 1/(k+1) with reciprocals read from an external ROM.
module exp_taylor_ctrl
  import exp_pkg::*;
#(
  parameter int N_TERMS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [X_W-1:0]    x_i,
  output logic              rom_en_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [X_W-1:0]    rom_dout_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [SUM_W-1:0]  result_o
);

  localparam logic [ADDR_W-1:0] LAST_N = ADDR_W'(N_TERMS - 1);

  state_e              state_q;
  logic [X_W-1:0]      x_q;
  logic [TERM_W-1:0]   term_q;
  logic [SUM_W-1:0]    sum_q;
  logic [ADDR_W-1:0]   n_q;
  logic                busy_q;
  logic                done_q;
  logic                rom_en_q;
  logic [ADDR_W-1:0]   rom_addr_q;

  logic [X_W-1:0]      mul_b;
  logic [TERM_W-1:0]   term_d;

  // One multiplier serves both steps: term*x in FETCH, term*(1/(k+1)) in MUL.
  assign mul_b = (state_q == MUL) ? rom_dout_i : x_q;

  fx_mul_trunc u_mul (
    .a_i (term_q),
    .b_i (mul_b),
    .p_o (term_d)
  );

  // NOTE: every register here uses <= so all updates see the pre-edge values;
  // a blocking = would let later statements read already-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      term_q     <= '0;
      sum_q      <= '0;
      n_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            x_q        <= x_i;
            term_q     <= ONE_Q16;
            sum_q      <= {1'b0, ONE_Q16};
            n_q        <= '0;
            busy_q     <= 1'b1;
            rom_en_q   <= 1'b1;
            rom_addr_q <= '0;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          term_q   <= term_d;
          rom_en_q <= 1'b0;
          state_q  <= MUL;
        end
        MUL: begin
          term_q  <= term_d;
          state_q <= ACC;
        end
        ACC: begin
          sum_q <= sum_q + {1'b0, term_q};
          if (n_q == LAST_N) begin
            state_q <= DONE;
          end else begin
            n_q        <= n_q + 4'd1;
            rom_en_q   <= 1'b1;
            rom_addr_q <= n_q + 4'd1;
            state_q    <= FETCH;
          end
        end
        DONE: begin
          // The done flag is registered out of DONE, so it pulses in the
          // following IDLE cycle: 3*N_TERMS+1 edges after start is sampled.
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          busy_q   <= 1'b0;
          rom_en_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign rom_en_o   = rom_en_q;
  assign rom_addr_o = rom_addr_q;
  assign result_o   = sum_q;

endmodule : exp_taylor_ctrl

// File: tb/tb_exp_taylor_ctrl.sv
// Scoreboard bench for exp_taylor_ctrl: four instances (N_TERMS 1, 2, 8, 16),
// each with its own registered reciprocal ROM, checked against a series model.
module tb_exp_taylor_ctrl;

  localparam int NI = 4;
  localparam int NT_TAB [NI] = '{1, 2, 8, 16};

  typedef struct {
    int          inst;
    logic [17:0] res;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_v    [NI];
  logic [15:0] x_v        [NI];
  logic        rom_en_v   [NI];
  logic [3:0]  rom_addr_v [NI];
  logic        busy_v     [NI];
  logic        done_v     [NI];
  logic [17:0] result_v   [NI];

  exp_t sb_q [$];
  int   exp_addr [NI];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  initial forever @(posedge clk) cyc++;

  function automatic logic [15:0] rom_val(input int k);
    if (k == 0) return 16'hFFFF;
    return 16'(65536 / (k + 1));
  endfunction

  // e^x ~ 1 + sum_{k=1..n} x^k/k!, each term built from the previous one by
  // multiplying with x and with the truncated reciprocal 1/k, both truncated.
  function automatic logic [17:0] ref_exp(input logic [15:0] x, input int n);
    longint term = 65536;
    longint sum  = 65536;
    for (int k = 0; k < n; k++) begin
      term = (term * longint'(x)) >> 16;
      term = (term * longint'(rom_val(k))) >> 16;
      sum  = sum + term;
    end
    return 18'(sum);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [15:0] rom_q;

    always @(posedge clk) if (rom_en_v[g]) rom_q <= rom_val(int'(rom_addr_v[g]));

    exp_taylor_ctrl #(.N_TERMS(NT_TAB[g])) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_v[g]),
      .x_i        (x_v[g]),
      .rom_en_o   (rom_en_v[g]),
      .rom_addr_o (rom_addr_v[g]),
      .rom_dout_i (rom_q),
      .busy_o     (busy_v[g]),
      .done_o     (done_v[g]),
      .result_o   (result_v[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse and tracks ROM addresses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < NI; i++) begin
          if (done_v[i]) begin
            if (sb_q.size() == 0) begin
              n_vec++;
              n_miss++;
              $display("FAIL unexpected_done: inst %0d result 0x%0h, no request pending", i,
                       result_v[i]);
            end else begin
              e = sb_q.pop_front();
              check($sformatf("done_inst%0d", i), i, e.inst);
              check($sformatf("result_inst%0d", i), 32'(result_v[i]), 32'(e.res));
              check($sformatf("latency_inst%0d", i), cyc, e.due);
              check($sformatf("busy_at_done_inst%0d", i), 32'(busy_v[i]), 0);
            end
          end
          if (rom_en_v[i]) begin
            check($sformatf("rom_addr_inst%0d", i), 32'(rom_addr_v[i]), exp_addr[i]);
            exp_addr[i] = (exp_addr[i] + 1) % NT_TAB[i];
          end
        end
      end
    end
  end

  task automatic push_exp(input int i, input logic [17:0] res, input int accept_edge);
    sb_q.push_back('{inst: i, res: res, due: accept_edge + 3 * NT_TAB[i] + 1});
  endtask

  // One computation; with noise, x and start are randomised while busy.
  task automatic run(input int i, input logic [15:0] x, input bit noise,
                     input bit use_exp, input logic [17:0] exp_res);
    int nt = NT_TAB[i];
    @(negedge clk);
    start_v[i] = 1'b1;
    x_v[i]     = x;
    push_exp(i, use_exp ? exp_res : ref_exp(x, nt), cyc + 1);
    for (int k = 1; k <= 3 * nt + 1; k++) begin
      @(negedge clk);
      start_v[i] = noise ? 1'($urandom_range(1)) : 1'b0;
      x_v[i]     = noise ? 16'($urandom) : x;
    end
    @(negedge clk);
    start_v[i] = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    sb_q.delete();
    for (int i = 0; i < NI; i++) exp_addr[i] = 0;
  endtask

  initial begin
    int c0;
    for (int i = 0; i < NI; i++) begin
      start_v[i]  = 1'b0;
      x_v[i]      = '0;
      exp_addr[i] = 0;
    end
    apply_reset();
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_busy%0d", i), 32'(busy_v[i]), 0);
      check($sformatf("rst_done%0d", i), 32'(done_v[i]), 0);
      check($sformatf("rst_rom_en%0d", i), 32'(rom_en_v[i]), 0);
      check($sformatf("rst_rom_addr%0d", i), 32'(rom_addr_v[i]), 0);
      check($sformatf("rst_result%0d", i), 32'(result_v[i]), 0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with hand-derived results.
    run(2, 16'h0000, 1'b0, 1'b1, 18'h1_0000);
    run(0, 16'h8000, 1'b0, 1'b1, 18'h1_7FFF);
    run(1, 16'h8000, 1'b0, 1'b1, 18'h1_9FFE);

    // start held high for three back-to-back runs (period 3*2+2 = 8 edges);
    // x is 0x8000 only on the accepting edges and random otherwise.
    @(negedge clk);
    c0 = cyc;
    start_v[1] = 1'b1;
    x_v[1]     = 16'h8000;
    for (int k = 0; k < 3; k++) push_exp(1, 18'h1_9FFE, c0 + 1 + 8 * k);
    for (int step = 1; step <= 17; step++) begin
      @(negedge clk);
      if (step <= 16)
        check($sformatf("held_busy_step%0d", step), 32'(busy_v[1]), (step % 8 == 0) ? 0 : 1);
      x_v[1] = (step % 8 == 0) ? 16'h8000 : 16'($urandom);
      if (step == 17) start_v[1] = 1'b0;
    end
    repeat (8) @(negedge clk);

    // Reset asserted during the second MUL must clear outputs without a clock.
    @(negedge clk);
    c0 = cyc;
    start_v[1] = 1'b1;
    x_v[1]     = 16'h8000;
    repeat (5) begin
      @(negedge clk);
      start_v[1] = 1'b0;
    end
    #2;
    apply_reset();
    #1;
    check("abort_busy", 32'(busy_v[1]), 0);
    check("abort_rom_en", 32'(rom_en_v[1]), 0);
    check("abort_result", 32'(result_v[1]), 0);
    check("abort_done", 32'(done_v[1]), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    run(1, 16'h8000, 1'b0, 1'b1, 18'h1_9FFE);

    // x just below 1.0 with all 16 terms: close to e in Q2.16.
    run(3, 16'hFFFF, 1'b0, 1'b0, '0);
    check("e_within_0x40",
          32'((result_v[3] >= 18'h2_B7A1) && (result_v[3] <= 18'h2_B821)), 1);

    // Randomised operands with start/x noise while busy.
    for (int r = 0; r < 6; r++) run(2, 16'($urandom), 1'b1, 1'b0, '0);
    for (int r = 0; r < 3; r++) run(3, 16'($urandom), 1'b1, 1'b0, '0);
    for (int r = 0; r < 4; r++) run(0, 16'($urandom), 1'b1, 1'b0, '0);
    for (int r = 0; r < 4; r++) run(1, 16'($urandom), 1'b1, 1'b0, '0);

    repeat (4) @(negedge clk);
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_vec++;
      n_miss++;
      $display("FAIL missing_done: inst %0d expected 0x%0h at cycle %0d, done never pulsed",
               e.inst, e.res, e.due);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule : tb_exp_taylor_ctrl

// File: doc/exp_taylor_ctrl.md
EXP_TAYLOR_CTRL -- requirements
Module: exp_taylor_ctrl

Interface
REQ-001 The block SHALL have one parameter: N_TERMS, default 8, number of Taylor terms summed after the constant 1.0 (legal range 1..16).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 start  input  1  request to compute; sampled only in IDLE.
REQ-005 x  input  16  unsigned Q0.16 operand, 0 <= x < 1.0.
REQ-006 rom_en  output  1  read enable to the reciprocal ROM.
REQ-007 rom_addr  output  4  ROM address; entry k holds 1/(k+1) in Q0.16 (entry 0 = 0xFFFF).
REQ-008 rom_dout  input  16  ROM registered read data, valid the cycle after rom_en sampled high.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  single-cycle pulse, result valid.
REQ-011 result  output  18  unsigned Q2.16 approximation of e^x.

Function
REQ-012 States SHALL be IDLE, FETCH, MUL, ACC, DONE.
REQ-013 IDLE with start=1: latch x, term <= 0x10000 (17-bit Q1.16), sum <= 0x10000 (18-bit Q2.16), n <= 0, go FETCH.
REQ-014 FETCH: rom_en=1, rom_addr=n; term <= (term * x_latched)[32:16] (truncate); go MUL.
REQ-015 MUL: term <= (term * rom_dout)[32:16] (truncate); go ACC.
REQ-016 ACC: sum <= sum + term; if n == N_TERMS-1 go DONE, else n <= n+1 and go FETCH.
REQ-017 DONE: done=1 for exactly one cycle; unconditional go IDLE.
REQ-018 result SHALL be driven from sum and hold its value from DONE until the next start is accepted.
REQ-019 Latency: done SHALL rise exactly 3*N_TERMS+1 rising edges after the edge that samples start.
REQ-020 rom_en SHALL be 0 in every state except FETCH; rom_addr SHALL hold last value when rom_en=0.
REQ-021 start while busy (including DONE) SHALL be ignored; x changes while busy SHALL not affect the result.
REQ-022 No overflow handling needed: term <= 1.0 and sum < 3.0 for all legal x; sum addition is 18-bit unsigned, no saturation.
REQ-023 rom_addr sequence per computation SHALL be 0,1,...,N_TERMS-1, one address per FETCH.

Reset
REQ-024 rst=0 SHALL asynchronously force state IDLE, busy=0, done=0, rom_en=0, rom_addr=0, result/sum=0, term=0, n=0, x_latched=0.
REQ-025 Reset mid-computation SHALL abort it; no done pulse is produced for the aborted request.
REQ-026 After rst release, the first start SHALL be accepted on the first rising edge where rst=1 and start=1.

Structure
REQ-027 A shared package exp_pkg SHALL hold the state enum, Q-format widths (X_W=16, TERM_W=17, SUM_W=18), ONE_Q16=0x10000.
REQ-028 One sub-module fx_mul_trunc (17x16 unsigned multiply, returns bits [32:16], combinational) SHALL be instantiated once and shared by FETCH and MUL via operand mux.
REQ-029 The ROM SHALL remain a separate instance; this block only drives its en/addr and reads its data.

Verification
REQ-030 x=0x0000, N_TERMS=8, start pulse -> done after 25 edges, result=0x10000.
REQ-031 x=0x8000, N_TERMS=1 -> term after FETCH 0x8000, after MUL 0x7FFF; result=0x17FFF, done after 4 edges.
REQ-032 x=0x8000, N_TERMS=2 -> second term 0x1FFF; result=0x19FFE; rom_addr observed 0 then 1 with rom_en high one cycle each.
REQ-033 start held high continuously with x=0x8000, N_TERMS=2 -> exactly one computation per IDLE visit, busy low exactly one cycle between runs, x toggled mid-run does not change 0x19FFE.
REQ-034 rst=0 asserted during second MUL -> busy, rom_en, result go 0 immediately (no clock), no done pulse; next start gives correct result.
REQ-035 x=0xFFFF, N_TERMS=16 -> result within 0x40 LSB of 0x2B7E1 (e in Q2.16), rom_addr covers 0..15.
